// File: rtl/bitstream_carry_resolver_pkg.sv
// rtl/bitstream_carry_resolver_pkg.sv - shared encodings for the carry resolver slice
//
// Purpose: lane flag encodings, word field positions, FSM state type and a
// helper that turns a lane flag into its word count.
package bitstream_carry_resolver_pkg;

    localparam logic [1:0] PB_NONE = 2'b00;
    localparam logic [1:0] PB_ONE  = 2'b01;
    localparam logic [1:0] PB_TWO  = 2'b10;
    localparam logic [1:0] PB_RSVD = 2'b11;

    localparam int         CARRY_BIT = 8;
    localparam logic [7:0] BYTE_FF   = 8'hFF;

    localparam int NUM_LANES = 4;
    localparam int NUM_SLOTS = 2 * NUM_LANES;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Reserved flag carries no words; the caller flags it separately.
    function automatic logic [1:0] words_in_lane(input logic [1:0] flag);
        case (flag)
            PB_NONE: return 2'd0;
            PB_ONE:  return 2'd1;
            PB_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/bitstream_carry_resolver_pb_word_fifo.sv
// rtl/bitstream_carry_resolver_pb_word_fifo.sv - multi-write compacting word FIFO
//
// Purpose: accepts up to NWR words per cycle (any subset of slots, packed in
// slot order), delivers one word per cycle.
// Ports:
//   general_clk, reset      clock, asynchronous active-low reset
//   wr_en[NWR], wr_data     per-slot write strobes and data
//   rd_en                   pop head (ignored when empty)
//   rd_data                 head word (valid when !empty)
//   empty, free             status; free = unused entries
module bitstream_carry_resolver_pb_word_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 9,
    parameter int NWR    = 8,
    parameter int AW     = $clog2(DEPTH),
    parameter int CW     = $clog2(DEPTH) + 1
) (
    input  logic                       general_clk,
    input  logic                       reset,
    input  logic [NWR-1:0]             wr_en,
    input  logic [NWR-1:0][DATA_W-1:0] wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       empty,
    output logic [CW-1:0]              free
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [CW-1:0]     count;
    logic [AW-1:0]     slot [NWR];
    logic [CW-1:0]     wr_cnt;
    logic              rd_go;

    // Each enabled slot lands at wptr plus the number of enabled slots before it.
    always_comb begin
        wr_cnt = '0;
        for (int i = 0; i < NWR; i++) begin
            slot[i] = wptr + wr_cnt[AW-1:0];
            if (wr_en[i]) begin
                wr_cnt = wr_cnt + 1'b1;
            end
        end
    end

    assign empty   = (count == '0);
    assign rd_go   = rd_en && !empty;
    assign rd_data = mem[rptr];
    assign free    = CW'(DEPTH) - count;

    always_ff @(posedge general_clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + wr_cnt[AW-1:0];
            rptr  <= rptr + {{(AW-1){1'b0}}, rd_go};
            count <= count + wr_cnt - {{(CW-1){1'b0}}, rd_go};
        end
    end

    always_ff @(posedge general_clk) begin
        for (int i = 0; i < NWR; i++) begin
            if (wr_en[i]) begin
                mem[slot[i]] <= wr_data[i];
            end
        end
    end

endmodule

// File: rtl/bitstream_carry_resolver.sv
// rtl/bitstream_carry_resolver.sv - resolves carries in 4-lane pre-bitstream words into bytes
//
// Purpose: queues lane words, tracks the pending byte P and the 0xFF run R,
// and emits resolved bytes one per cycle; flush drains P/R at frame end.
// Ports:
//   general_clk, reset            clock, asynchronous active-low reset
//   in_valid/in_ready             lane group handshake
//   in_flag_k, in_word_k_1/_2     lane k word count and words
//   flush                         end-of-frame pulse
//   out_byte/out_valid/out_ready  resolved byte stream
//   done                          pulse after the last flushed byte
//   err                           sticky protocol error
module bitstream_carry_resolver
    import bitstream_carry_resolver_pkg::*;
#(
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int RUN_W      = 16
) (
    input  logic              general_clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_flag_1,
    input  logic [1:0]        in_flag_2,
    input  logic [1:0]        in_flag_3,
    input  logic [1:0]        in_flag_4,
    input  logic [WORD_W-1:0] in_word_1_1,
    input  logic [WORD_W-1:0] in_word_1_2,
    input  logic [WORD_W-1:0] in_word_2_1,
    input  logic [WORD_W-1:0] in_word_2_2,
    input  logic [WORD_W-1:0] in_word_3_1,
    input  logic [WORD_W-1:0] in_word_3_2,
    input  logic [WORD_W-1:0] in_word_4_1,
    input  logic [WORD_W-1:0] in_word_4_2,
    input  logic              flush,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done,
    output logic              err
);

    localparam int         FREE_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [RUN_W-1:0] R_MAX = {RUN_W{1'b1}};

    logic [1:0]        lane_flag [NUM_LANES];
    logic [WORD_W-1:0] lane_w1   [NUM_LANES];
    logic [WORD_W-1:0] lane_w2   [NUM_LANES];

    assign lane_flag[0] = in_flag_1;
    assign lane_flag[1] = in_flag_2;
    assign lane_flag[2] = in_flag_3;
    assign lane_flag[3] = in_flag_4;
    assign lane_w1[0]   = in_word_1_1;
    assign lane_w2[0]   = in_word_1_2;
    assign lane_w1[1]   = in_word_2_1;
    assign lane_w2[1]   = in_word_2_2;
    assign lane_w1[2]   = in_word_3_1;
    assign lane_w2[2]   = in_word_3_2;
    assign lane_w1[3]   = in_word_4_1;
    assign lane_w2[3]   = in_word_4_2;

    logic                      push;
    logic [NUM_SLOTS-1:0]      wr_en;
    logic [NUM_SLOTS-1:0][8:0] wr_data;
    logic                      in_err;
    logic                      pop;
    logic [8:0]                rd_data;
    logic                      fifo_empty;
    logic [FREE_W-1:0]         fifo_free;

    state_t           state, state_n;
    logic [7:0]       p_byte, p_byte_n;
    logic             p_valid, p_valid_n;
    logic [RUN_W-1:0] r_cnt, r_cnt_n;
    logic [7:0]       head_byte, head_byte_n;
    logic [7:0]       run_byte, run_byte_n;
    logic [RUN_W-1:0] run_cnt, run_cnt_n;
    logic             final_emit, final_emit_n;
    logic             flush_req, flush_req_n;
    logic             err_set;
    logic             word_c;
    logic [7:0]       word_b;

    assign push = in_valid && in_ready;

    // Words with a reserved flag or stray high bits are dropped, not queued.
    always_comb begin
        wr_en   = '0;
        wr_data = '0;
        in_err  = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            wr_data[2*k]   = lane_w1[k][8:0];
            wr_data[2*k+1] = lane_w2[k][8:0];
            if (push) begin
                if (lane_flag[k] == PB_RSVD) begin
                    in_err = 1'b1;
                end
                if (words_in_lane(lane_flag[k]) != 2'd0) begin
                    if (|lane_w1[k][WORD_W-1:9]) begin
                        in_err = 1'b1;
                    end else begin
                        wr_en[2*k] = 1'b1;
                    end
                end
                if (words_in_lane(lane_flag[k]) == 2'd2) begin
                    if (|lane_w2[k][WORD_W-1:9]) begin
                        in_err = 1'b1;
                    end else begin
                        wr_en[2*k+1] = 1'b1;
                    end
                end
            end
        end
    end

    bitstream_carry_resolver_pb_word_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (9),
        .NWR    (NUM_SLOTS)
    ) u_fifo (
        .general_clk (general_clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (pop),
        .rd_data     (rd_data),
        .empty       (fifo_empty),
        .free        (fifo_free)
    );

    assign word_c = rd_data[CARRY_BIT];
    assign word_b = rd_data[7:0];

    // Keeping 8 free slots means a full lane group always fits.
    assign in_ready  = (fifo_free >= FREE_W'(8)) && !flush_req;
    assign out_valid = (state == ST_HEAD) || (state == ST_RUN);
    assign out_byte  = (state == ST_HEAD) ? head_byte :
                       (state == ST_RUN)  ? run_byte  : 8'h00;
    assign done      = (state == ST_DONE);

    // A new flush pulse during DONE starts the next drain request.
    assign flush_req_n = (flush_req && (state != ST_DONE)) || flush;

    always_comb begin
        state_n      = state;
        p_byte_n     = p_byte;
        p_valid_n    = p_valid;
        r_cnt_n      = r_cnt;
        head_byte_n  = head_byte;
        run_byte_n   = run_byte;
        run_cnt_n    = run_cnt;
        final_emit_n = final_emit;
        pop          = 1'b0;
        err_set      = in_err;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (!p_valid) begin
                        p_byte_n  = word_b;
                        p_valid_n = 1'b1;
                        if (word_c) err_set = 1'b1;
                    end else if (!word_c && word_b == BYTE_FF) begin
                        if (r_cnt == R_MAX) err_set = 1'b1;
                        else                r_cnt_n = r_cnt + 1'b1;
                    end else if (!word_c) begin
                        head_byte_n  = p_byte;
                        run_byte_n   = BYTE_FF;
                        run_cnt_n    = r_cnt;
                        p_byte_n     = word_b;
                        r_cnt_n      = '0;
                        final_emit_n = 1'b0;
                        state_n      = ST_HEAD;
                    end else if (word_b != BYTE_FF) begin
                        head_byte_n  = p_byte + 8'd1;
                        run_byte_n   = 8'h00;
                        run_cnt_n    = r_cnt;
                        p_byte_n     = word_b;
                        r_cnt_n      = '0;
                        final_emit_n = 1'b0;
                        state_n      = ST_HEAD;
                    end else if (r_cnt != '0) begin
                        // The carried FF run becomes zeros; the incoming FF
                        // becomes 00 pending plus a fresh run of one.
                        head_byte_n  = p_byte + 8'd1;
                        run_byte_n   = 8'h00;
                        run_cnt_n    = r_cnt - 1'b1;
                        p_byte_n     = 8'h00;
                        r_cnt_n      = {{(RUN_W-1){1'b0}}, 1'b1};
                        final_emit_n = 1'b0;
                        state_n      = ST_HEAD;
                    end else begin
                        if (p_byte == BYTE_FF) err_set = 1'b1;
                        p_byte_n = p_byte + 8'd1;
                        r_cnt_n  = {{(RUN_W-1){1'b0}}, 1'b1};
                    end
                end else if (flush_req) begin
                    if (p_valid) begin
                        head_byte_n  = p_byte;
                        run_byte_n   = BYTE_FF;
                        run_cnt_n    = r_cnt;
                        final_emit_n = 1'b1;
                        p_valid_n    = 1'b0;
                        r_cnt_n      = '0;
                        state_n      = ST_HEAD;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_HEAD: begin
                if (out_ready) begin
                    if (run_cnt != '0)   state_n = ST_RUN;
                    else if (final_emit) state_n = ST_DONE;
                    else                 state_n = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (out_ready) begin
                    run_cnt_n = run_cnt - 1'b1;
                    if (run_cnt == RUN_W'(1)) begin
                        state_n = final_emit ? ST_DONE : ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                p_valid_n    = 1'b0;
                r_cnt_n      = '0;
                final_emit_n = 1'b0;
                state_n      = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge general_clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            p_byte     <= 8'h00;
            p_valid    <= 1'b0;
            r_cnt      <= '0;
            head_byte  <= 8'h00;
            run_byte   <= 8'h00;
            run_cnt    <= '0;
            final_emit <= 1'b0;
            flush_req  <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            p_byte     <= p_byte_n;
            p_valid    <= p_valid_n;
            r_cnt      <= r_cnt_n;
            head_byte  <= head_byte_n;
            run_byte   <= run_byte_n;
            run_cnt    <= run_cnt_n;
            final_emit <= final_emit_n;
            flush_req  <= flush_req_n;
            err        <= err | err_set;
        end
    end

endmodule
